// File: rtl/iram_pkg.sv
// Shared definitions for the instruction-memory image loader.
package iram_pkg;

  localparam int          IRAM_DEPTH        = 512;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/iram_loader.sv
// Framed byte-stream writer for the instruction memory; holds the CPU in reset
// until a complete image with a good checksum has been written.
module iram_loader
  import iram_pkg::*;
#(
  parameter int         ADDR_WIDTH = $clog2(IRAM_DEPTH),
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  localparam logic [15:0] MAX_LEN = 16'(2 ** ADDR_WIDTH);

  state_t              state, state_nx;
  logic [7:0]          len_hi;
  logic [ADDR_WIDTH:0] len;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic [7:0]          sum;
  logic [15:0]         len_full;
  logic                len_ok;
  logic                acc;
  logic                csum_ok;

  assign rx_ready = !reset && (state != S_DONE) && (state != S_ERR);
  assign busy     = (state != S_IDLE);
  assign acc      = rx_valid && rx_ready;
  assign len_full = {len_hi, rx_data};
  assign len_ok   = (len_full != 16'd0) && (len_full <= MAX_LEN);
  assign cnt_inc  = cnt + 1'b1;
  // sum already holds every payload byte by the time CSUM is accepted
  assign csum_ok  = (rx_data == sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (acc && rx_data == SYNC_BYTE) state_nx = S_LEN_HI;
      S_LEN_HI: if (acc) state_nx = S_LEN_LO;
      S_LEN_LO: if (acc) state_nx = len_ok ? S_DATA : S_ERR;
      S_DATA:   if (acc && cnt_inc == len) state_nx = S_CSUM;
      S_CSUM:   if (acc) state_nx = csum_ok ? S_DONE : S_ERR;
      S_DONE:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Status flags move on the accepting edge so they are visible in the
  // DONE/ERR cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      if (acc) begin
        case (state)
          S_IDLE: if (rx_data == SYNC_BYTE) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: if (len_ok) begin
            len <= len_full[ADDR_WIDTH:0];
            cnt <= '0;
            sum <= '0;
          end else begin
            error <= 1'b1;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt[ADDR_WIDTH-1:0];
            mem_wdata <= rx_data[DATA_WIDTH-1:0];
            sum       <= sum + rx_data;
            cnt       <= cnt_inc;
          end
          S_CSUM: if (csum_ok) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Randomized frame stimulus against a frame-level model of expected writes and flags.
module tb_iram_loader;
  import iram_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         due;
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, mem_we, busy, done, error, cpu_hold;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  iram_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: expected write queue (with the cycle each write must appear),
  // expected flags, and the expected memory image.
  wr_t        wq[$];
  int         exp_done = 0, exp_err = 0, exp_hold = 1;
  int         pend_cyc = -1, pend_done = 0, pend_err = 0, pend_hold = 1;
  logic [7:0] exp_mem[512];
  logic [7:0] shadow[512];
  int         gap_pct = 0;

  initial for (int i = 0; i < 512; i++) begin exp_mem[i] = 8'h00; shadow[i] = 8'h00; end

  wr_t w;
  always @(negedge clk) begin
    if (pend_cyc == cyc) begin
      exp_done = pend_done; exp_err = pend_err; exp_hold = pend_hold; pend_cyc = -1;
    end
    if (reset) begin
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
    end else begin
      chk("done", done, exp_done);
      chk("error", error, exp_err);
      chk("cpu_hold", cpu_hold, exp_hold);
      if (mem_we) begin
        if (wq.size() == 0) chk("spurious_we", 1, 0);
        else begin
          w = wq.pop_front();
          chk("we_cycle", cyc, w.due);
          chk("we_addr", mem_addr, w.addr);
          chk("we_data", mem_wdata, w.data);
          shadow[mem_addr] = mem_wdata;
        end
      end else if (wq.size() > 0 && wq[0].due <= cyc) begin
        chk("missing_we", 0, 1);
        void'(wq.pop_front());
      end
    end
  end

  // Present one byte (after optional idle gap) and wait for acceptance.
  // acc_cyc is the cycle in which effects of the acceptance become visible.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int tries = 0;
    acc_cyc = -1;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(negedge clk); rx_valid = 1'b0;
    end
    forever begin
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      if (rx_ready) begin
        acc_cyc = cyc + 1;
        @(posedge clk); #1 rx_valid = 1'b0;
        break;
      end
      if (++tries > 50) begin
        chk("accept_timeout", 0, 1);
        rx_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic end_checks();
    @(negedge clk);
    chk("end_busy", busy, 1);
    chk("end_rx_ready", rx_ready, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rx_ready", rx_ready, 1);
  endtask

  task automatic send_frame(input logic [15:0] nlen, input bq_t pl, input logic [7:0] cs);
    int c;
    logic [7:0] s = 8'h00;
    send_byte(SYNC_BYTE_DEFAULT, c);
    pend_cyc = c; pend_done = 0; pend_err = 0; pend_hold = 1;
    send_byte(nlen[15:8], c);
    send_byte(nlen[7:0], c);
    if (nlen == 16'd0 || nlen > 16'd512) begin
      pend_cyc = c; pend_done = 0; pend_err = 1; pend_hold = 1;
      end_checks();
      return;
    end
    for (int i = 0; i < int'(nlen); i++) begin
      send_byte(pl[i], c);
      wq.push_back('{due: c, addr: 9'(i), data: pl[i]});
      exp_mem[i] = pl[i];
      s = s + pl[i];
    end
    send_byte(cs, c);
    pend_cyc = c;
    pend_done = (s == cs) ? 1 : 0;
    pend_err  = (s == cs) ? 0 : 1;
    pend_hold = (s == cs) ? 0 : 1;
    end_checks();
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    wq.delete();
    exp_done = 0; exp_err = 0; exp_hold = 1; pend_cyc = -1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  bq_t        p;
  logic [15:0] nl;
  logic [7:0]  cs, g;
  int          dummy, k, mis;

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Scenario 1: basic frame
    p = '{8'h36, 8'h0B, 8'h0C};
    send_frame(16'd3, p, 8'h4D);
    chk("lit_mem0", shadow[0], 8'h36);
    chk("lit_mem1", shadow[1], 8'h0B);
    chk("lit_mem2", shadow[2], 8'h0C);
    chk("lit_done", done, 1);
    chk("lit_hold_released", cpu_hold, 0);

    // Scenario 2: bad checksum
    send_frame(16'd3, p, 8'h4E);
    chk("lit_err", error, 1);
    chk("lit_err_done", done, 0);
    chk("lit_err_hold", cpu_hold, 1);

    // Scenario 3: illegal lengths
    p.delete();
    send_frame(16'd0, p, 8'h00);
    chk("lit_len0_err", error, 1);
    send_frame(16'd513, p, 8'h00);
    chk("lit_len513_err", error, 1);

    // Scenario 4: garbage before sync, gaps in payload
    send_byte(8'h00, dummy); send_byte(8'hFF, dummy); send_byte(8'h12, dummy);
    gap_pct = 40;
    p = '{8'h36, 8'h0B, 8'h0C};
    send_frame(16'd3, p, 8'h4D);
    chk("lit_gap_done", done, 1);
    gap_pct = 0;

    // Scenario 5: full-depth frame
    p.delete();
    for (int i = 0; i < 512; i++) p.push_back(8'(i));
    send_frame(16'd512, p, 8'h00);
    chk("lit_full_last", shadow[511], 8'hFF);
    chk("lit_full_256", shadow[256], 8'h00);
    chk("lit_full_done", done, 1);

    // Scenario 6: reset mid-frame, then a good frame
    send_byte(SYNC_BYTE_DEFAULT, dummy);
    pend_cyc = dummy; pend_done = 0; pend_err = 0; pend_hold = 1;
    send_byte(8'h00, dummy); send_byte(8'h05, dummy);
    send_byte(8'h11, dummy); wq.push_back('{due: dummy, addr: 9'd0, data: 8'h11}); exp_mem[0] = 8'h11;
    send_byte(8'h22, dummy); wq.push_back('{due: dummy, addr: 9'd1, data: 8'h22}); exp_mem[1] = 8'h22;
    do_reset();
    p = '{8'h01, 8'h02, 8'h03, 8'hA5};
    send_frame(16'd4, p, 8'hAB);
    chk("lit_after_rst_done", done, 1);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      gap_pct = $urandom_range(50);
      k = $urandom_range(3);
      repeat (k) begin
        g = 8'($urandom_range(255));
        if (g == SYNC_BYTE_DEFAULT) g = 8'h00;
        send_byte(g, dummy);
      end
      p.delete();
      cs = 8'h00;
      if ($urandom_range(9) == 0)
        nl = ($urandom_range(1) == 1) ? 16'd0 : 16'($urandom_range(65535, 513));
      else begin
        nl = 16'($urandom_range(40, 1));
        for (int j = 0; j < int'(nl); j++) begin
          p.push_back(8'($urandom));
          cs = cs + p[j];
        end
        if ($urandom_range(3) == 0) cs = cs + 8'($urandom_range(255, 1));
      end
      send_frame(nl, p, cs);
    end
    gap_pct = 0;

    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    mis = 0;
    for (int i = 0; i < 512; i++) if (shadow[i] !== exp_mem[i]) mis++;
    chk("mem_image_mismatches", mis, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
